// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM states,
// default bus timeout and the MEM/WB control bubble.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    localparam int DEFAULT_TIMEOUT = 255;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } wb_ctrl_t;

    localparam wb_ctrl_t WB_BUBBLE = '{mem_to_reg: 1'b0, reg_write: 1'b0};

endpackage

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register. A bubble clears only the control fields;
// the data fields hold so writeback sees stable values during a stall.
module mem_wb_register
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic        mem_to_reg,
    input  logic        reg_write,
    input  logic [31:0] read_data,
    input  logic [31:0] alu_result,
    input  logic [4:0]  write_reg,
    output logic        wb_mem_to_reg,
    output logic        wb_reg_write,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_alu_result,
    output logic [4:0]  wb_write_reg
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_mem_to_reg <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_read_data  <= '0;
            wb_alu_result <= '0;
            wb_write_reg  <= '0;
        end else if (bubble) begin
            wb_mem_to_reg <= WB_BUBBLE.mem_to_reg;
            wb_reg_write  <= WB_BUBBLE.reg_write;
        end else if (load) begin
            wb_mem_to_reg <= mem_to_reg;
            wb_reg_write  <= reg_write;
            wb_read_data  <= read_data;
            wb_alu_result <= alu_result;
            wb_write_reg  <= write_reg;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: word loads/stores over a req/ack bus with timeout,
// upstream stall while an access is outstanding, and the MEM/WB register.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_mem_to_reg,
    input  logic        in_reg_write,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_write_data,
    input  logic [4:0]  in_write_reg,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        stall,
    output logic        mem_fault,
    output logic        wb_mem_to_reg,
    output logic        wb_reg_write,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_alu_result,
    output logic [4:0]  wb_write_reg
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      cap_data;
    logic             cap_fault;
    logic             mem_op;
    logic             bad_op;
    logic             cnt_last;
    logic [31:0]      sel_data;
    logic             sel_reg_write;

    assign cnt_last = (cnt == CNT_W'(TIMEOUT - 1));

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        mem_op        = in_mem_read | in_mem_write;
        bad_op        = mem_op & ((in_alu_result[1:0] != 2'b00) | (in_mem_read & in_mem_write));
        state_next    = state;
        stall         = 1'b0;
        sel_data      = '0;
        sel_reg_write = in_reg_write;
        case (state)
            IDLE: begin
                if (bad_op) begin
                    sel_reg_write = 1'b0;
                end else if (mem_op) begin
                    stall      = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (bus_ack || cnt_last) begin
                    state_next = COMPLETE;
                end
            end
            COMPLETE: begin
                sel_data      = cap_data;
                sel_reg_write = in_reg_write & ~cap_fault;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            cap_data  <= '0;
            cap_fault <= 1'b0;
            mem_fault <= 1'b0;
        end else begin
            state     <= state_next;
            mem_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (bad_op) begin
                        mem_fault <= 1'b1;
                    end else if (mem_op) begin
                        bus_req   <= 1'b1;
                        bus_we    <= in_mem_write;
                        bus_addr  <= {in_alu_result[31:2], 2'b00};
                        bus_wdata <= in_write_data;
                        cnt       <= '0;
                        cap_fault <= 1'b0;
                    end
                end
                ACCESS: begin
                    // An ack in the final counted cycle still wins over the timeout.
                    if (bus_ack) begin
                        cap_data <= bus_rdata;
                        bus_req  <= 1'b0;
                    end else if (cnt_last) begin
                        bus_req   <= 1'b0;
                        mem_fault <= 1'b1;
                        cap_data  <= '0;
                        cap_fault <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    mem_wb_register u_mem_wb (
        .clk           (clk),
        .rst           (rst),
        .load          (~stall),
        .bubble        (stall),
        .mem_to_reg    (in_mem_to_reg),
        .reg_write     (sel_reg_write),
        .read_data     (sel_data),
        .alu_result    (in_alu_result),
        .write_reg     (in_write_reg),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_reg_write  (wb_reg_write),
        .wb_read_data  (wb_read_data),
        .wb_alu_result (wb_alu_result),
        .wb_write_reg  (wb_write_reg)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a bus responder with programmable ack
// delay, and a scoreboard of expected MEM/WB contents per instruction.
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_mem_to_reg, in_reg_write, in_mem_read, in_mem_write;
    logic [31:0] in_alu_result, in_write_data;
    logic [4:0]  in_write_reg;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        stall, mem_fault;
    logic        wb_mem_to_reg, wb_reg_write;
    logic [31:0] wb_read_data, wb_alu_result;
    logic [4:0]  wb_write_reg;

    typedef struct packed {
        logic        m2r;
        logic        rw;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  wreg;
    } wb_t;

    wb_t sb[$];
    int  total  = 0;
    int  passed = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_mem_to_reg (in_mem_to_reg),
        .in_reg_write  (in_reg_write),
        .in_mem_read   (in_mem_read),
        .in_mem_write  (in_mem_write),
        .in_alu_result (in_alu_result),
        .in_write_data (in_write_data),
        .in_write_reg  (in_write_reg),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata),
        .bus_ack       (bus_ack),
        .stall         (stall),
        .mem_fault     (mem_fault),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_reg_write  (wb_reg_write),
        .wb_read_data  (wb_read_data),
        .wb_alu_result (wb_alu_result),
        .wb_write_reg  (wb_write_reg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic drive_nop();
        in_mem_to_reg = 1'b0;
        in_reg_write  = 1'b0;
        in_mem_read   = 1'b0;
        in_mem_write  = 1'b0;
        in_alu_result = '0;
        in_write_data = '0;
        in_write_reg  = '0;
    endtask

    // Presents one instruction, acts as the bus slave (ack in the ack_at-th
    // request cycle, 0 = never) and checks stall/req/fault counts and MEM/WB.
    task automatic do_op(input string tag, input logic rd, input logic wr,
                         input logic m2r, input logic rw,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] wreg, input int ack_at,
                         input logic [31:0] rdata, input int exp_stall,
                         input int exp_req, input int exp_fault);
        int   stall_cnt = 0;
        int   req_cnt   = 0;
        int   fault_cnt = 0;
        bit   done      = 1'b0;
        logic s;
        logic prev_s    = 1'b0;
        bit   bad, timed_out;
        wb_t  e, got;

        bad       = (rd | wr) && ((addr[1:0] != 2'b00) || (rd && wr));
        timed_out = (rd | wr) && !bad && (ack_at == 0 || ack_at > TO);
        e.m2r     = m2r;
        e.rw      = rw && !bad && !timed_out;
        e.rdata   = ((rd | wr) && !bad && !timed_out) ? rdata : 32'h0;
        e.alu     = addr;
        e.wreg    = wreg;
        sb.push_back(e);

        in_mem_read   = rd;
        in_mem_write  = wr;
        in_mem_to_reg = m2r;
        in_reg_write  = rw;
        in_alu_result = addr;
        in_write_data = wdata;
        in_write_reg  = wreg;
        #1;

        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            s = stall;
            if (prev_s) begin
                check({tag, ":bubble_reg_write"}, wb_reg_write, 0);
                check({tag, ":bubble_mem_to_reg"}, wb_mem_to_reg, 0);
            end
            if (cyc > 0 && mem_fault === 1'b1) fault_cnt++;
            if (bus_req === 1'b1) begin
                req_cnt++;
                check({tag, ":bus_we"}, bus_we, wr);
                check({tag, ":bus_addr"}, bus_addr, addr);
                check({tag, ":bus_wdata"}, bus_wdata, wdata);
                bus_ack   = (req_cnt == ack_at);
                bus_rdata = bus_ack ? rdata : ~rdata;
            end else begin
                bus_ack = 1'b0;
            end
            if (s === 1'b1) stall_cnt++;
            prev_s = s;
            @(negedge clk);
            #1;
            if (s !== 1'b1) done = 1'b1;
        end
        bus_ack = 1'b0;
        if (mem_fault === 1'b1) fault_cnt++;

        check({tag, ":completed"}, done, 1);
        check({tag, ":stall_cycles"}, stall_cnt, exp_stall);
        check({tag, ":req_cycles"}, req_cnt, exp_req);
        check({tag, ":fault_pulses"}, fault_cnt, exp_fault);
        check({tag, ":sb_nonempty"}, sb.size() > 0, 1);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check({tag, ":wb_mem_to_reg"}, wb_mem_to_reg, got.m2r);
            check({tag, ":wb_reg_write"}, wb_reg_write, got.rw);
            check({tag, ":wb_read_data"}, wb_read_data, got.rdata);
            check({tag, ":wb_alu_result"}, wb_alu_result, got.alu);
            check({tag, ":wb_write_reg"}, wb_write_reg, got.wreg);
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        drive_nop();
        repeat (2) @(negedge clk);
        #1;
        check("rst:bus_req", bus_req, 0);
        check("rst:bus_we", bus_we, 0);
        check("rst:bus_addr", bus_addr, 0);
        check("rst:bus_wdata", bus_wdata, 0);
        check("rst:mem_fault", mem_fault, 0);
        check("rst:stall", stall, 0);
        check("rst:wb_mem_to_reg", wb_mem_to_reg, 0);
        check("rst:wb_reg_write", wb_reg_write, 0);
        check("rst:wb_read_data", wb_read_data, 0);
        check("rst:wb_alu_result", wb_alu_result, 0);
        check("rst:wb_write_reg", wb_write_reg, 0);
        rst = 1'b0;
        @(negedge clk);
        #1;

        //     tag          rd    wr    m2r   rw    addr          wdata         wreg ack rdata         stall   req fault
        do_op("alu",        1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'h0,        5'd5, 0, 32'h0,         0,      0,  0);
        do_op("load",       1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h1111_2222, 5'd3, 1, 32'hDEAD_BEEF, 2,      1,  0);
        do_op("store",      1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 5'd0, 3, 32'h0BAD_0BAD, 4,      3,  0);
        do_op("misaligned", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0102, 32'h0,        5'd7, 1, 32'h1234_5678, 0,      0,  1);
        do_op("rd_and_wr",  1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0104, 32'h0,        5'd8, 1, 32'h1234_5678, 0,      0,  1);
        do_op("timeout",    1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0,        5'd9, 0, 32'hFFFF_FFFF, TO + 1, TO, 1);
        do_op("b2b_load",   1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h0,        5'd4, 1, 32'hA5A5_0001, 2,      1,  0);
        do_op("b2b_store",  1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0014, 32'h7777_8888, 5'd0, 2, 32'h0,         3,      2,  0);
        do_op("late_ack",   1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'h0,        5'd6, TO, 32'h600D_CAFE, TO + 1, TO, 0);
        do_op("alu2",       1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0ABC, 32'h0,        5'd2, 0, 32'h0,         0,      0,  0);

        // Reset in the second ACCESS cycle drops the access; a later ack is ignored.
        in_mem_read   = 1'b1;
        in_mem_to_reg = 1'b1;
        in_reg_write  = 1'b1;
        in_alu_result = 32'h0000_0400;
        in_write_reg  = 5'd10;
        #1;
        check("rsta:idle_stall", stall, 1);
        @(negedge clk);
        #1;
        check("rsta:access1_req", bus_req, 1);
        @(negedge clk);
        #1;
        check("rsta:access2_req", bus_req, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        drive_nop();
        #1;
        check("rsta:bus_req", bus_req, 0);
        check("rsta:stall", stall, 0);
        check("rsta:wb_reg_write", wb_reg_write, 0);
        check("rsta:wb_mem_to_reg", wb_mem_to_reg, 0);
        check("rsta:wb_read_data", wb_read_data, 0);
        check("rsta:wb_alu_result", wb_alu_result, 0);
        check("rsta:wb_write_reg", wb_write_reg, 0);
        bus_ack   = 1'b1;
        bus_rdata = 32'h55AA_55AA;
        @(negedge clk);
        #1;
        bus_ack = 1'b0;
        check("rsta:late_ack_req", bus_req, 0);
        check("rsta:late_ack_stall", stall, 0);
        check("rsta:late_ack_fault", mem_fault, 0);
        @(negedge clk);
        #1;
        check("rsta:late_ack_rdata", wb_read_data, 0);
        check("rsta:late_ack_reg_write", wb_reg_write, 0);
        check("sb:drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage of the processor core. Consumes the EX/MEM register outputs, performs word loads and stores on the external data bus over a req/ack handshake, and stalls the upstream pipeline while an access is outstanding. Drives the MEM/WB register, which is contained in this block, for the writeback stage.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles in ACCESS without bus_ack before the access is aborted. Legal range 1..65535.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_mem_to_reg  in  1  EX/MEM: writeback selects memory data.
- in_reg_write  in  1  EX/MEM: register write enable.
- in_mem_read  in  1  EX/MEM: load.
- in_mem_write  in  1  EX/MEM: store.
- in_alu_result  in  32  EX/MEM: byte address or ALU result.
- in_write_data  in  32  EX/MEM: store data.
- in_write_reg  in  5  EX/MEM: destination register.
- bus_req  out  1  access request, registered.
- bus_we  out  1  1 = write, registered.
- bus_addr  out  32  byte address, registered, word aligned.
- bus_wdata  out  32  store data, registered.
- bus_rdata  in  32  load data, valid when bus_ack=1.
- bus_ack  in  1  access complete.
- stall  out  1  combinational; upstream registers hold while this is 1.
- mem_fault  out  1  one-cycle pulse on a misaligned, illegal or timed-out access.
- wb_mem_to_reg, wb_reg_write  out  1 each  MEM/WB control.
- wb_read_data, wb_alu_result  out  32 each  MEM/WB data.
- wb_write_reg  out  5  MEM/WB destination.

## Operation
- mem_op = in_mem_read | in_mem_write. The op is bad if in_alu_result[1:0] != 0, or if in_mem_read and in_mem_write are both 1.
- FSM states: IDLE, ACCESS, COMPLETE.
- IDLE, no mem_op: stall=0. The instruction passes to MEM/WB, with wb_read_data set to 0.
- IDLE, bad mem_op: stall=0. No bus access. mem_fault pulses on the next cycle. The instruction passes with wb_reg_write forced to 0.
- IDLE, good mem_op: stall=1. On the edge, latch bus_addr, bus_we=in_mem_write and bus_wdata, set bus_req=1, and go to ACCESS.
- ACCESS: stall=1. bus_req stays 1, and bus outputs stay stable.
  - On bus_ack: capture bus_rdata, drop bus_req, go to COMPLETE.
  - If the timeout counter reaches TIMEOUT-1 with no ack: drop bus_req, pulse mem_fault, set captured data to 0, mark the op as faulted, go to COMPLETE.
- COMPLETE: stall=0. The MEM/WB register loads the captured data, with wb_reg_write forced to 0 if the op faulted. Go to IDLE.
- MEM/WB register when stall=0: loads the in_* fields and the data selected above.
- MEM/WB register when stall=1: loads a bubble (wb_reg_write=0, wb_mem_to_reg=0). The other wb_* outputs hold.
- bus_ack outside ACCESS is ignored.
- The timeout counter clears on entry to ACCESS. Its width is clog2(TIMEOUT+1).

## Timing
- Reset values: state IDLE, counter 0, and every output 0 (bus_req, bus_we, bus_addr, bus_wdata, mem_fault, all wb_*). stall evaluates to 0.
- Reset during ACCESS: bus_req is 0 in the cycle after the reset edge, and the pending access is dropped with no writeback.
- Non-memory op: wb_* outputs are valid one cycle after the op appears on the EX/MEM outputs.
- Memory op, minimum latency with ack in the first ACCESS cycle: IDLE cycle, ACCESS cycle, COMPLETE cycle. wb_* outputs are valid after the COMPLETE edge, so stall is high for 2 cycles.
- An ack after k ACCESS cycles gives stall high for k+1 cycles.
- Timeout: bus_req is high for exactly TIMEOUT cycles.
- mem_fault is exactly one cycle wide and never asserted on a successful access.
- Back-to-back memory ops: the second op is evaluated in the IDLE cycle that follows COMPLETE. There is no extra dead cycle.

## Structure
- Package mem_stage_pkg holds:
  - the state enum (IDLE, ACCESS, COMPLETE);
  - the default TIMEOUT constant;
  - the bubble value for the MEM/WB control fields.
- Sub-module mem_wb_register holds the MEM/WB register with its load and bubble inputs.
- The FSM, the bus registers and the timeout counter live in the top level.

## Test plan
- ALU op, in_reg_write=1, in_alu_result=0x1234, in_write_reg=5 → stall stays 0. Next cycle: wb_alu_result=0x1234, wb_write_reg=5, wb_reg_write=1.
- Load from 0x100, ack in the first ACCESS cycle with rdata 0xDEADBEEF → stall high for 2 cycles. bus_req high for 1 cycle with bus_we=0 and bus_addr=0x100. Then wb_read_data=0xDEADBEEF and wb_mem_to_reg=1.
- Store 0xCAFEF00D to 0x200, ack delayed 3 cycles → bus_we=1 and bus_wdata stable for 4 cycles. stall high for 4 cycles. wb_reg_write=0 during the stall.
- Load from address 0x102 → no bus_req, one mem_fault pulse, wb_reg_write=0. Repeat with in_mem_read=in_mem_write=1 → same response.
- TIMEOUT=4, no ack → bus_req high for exactly 4 cycles, then one mem_fault pulse, wb_read_data=0, wb_reg_write=0.
- rst asserted in the second ACCESS cycle → bus_req=0, stall=0 and all wb_*=0 after the reset edge. A later ack is ignored.
